// File: rtl/multi_channel_enable_generator.sv
// NUM_CH independent clock-enable dividers driven by one master enable.
// Divide ratios are reprogrammable at run time and take effect on each channel's own wrap or on sync.
module multi_channel_enable_generator #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic                                          sync,
  input  logic                                          cfg_wr,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                              cfg_div,
  output logic [NUM_CH-1:0]                             ce,
  output logic [NUM_CH-1:0]                             cfg_pending
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // A ratio of 0 is meaningless for a divider, so it is promoted to 1.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;
    logic             tick;
    logic             pend;
    logic             wr_hit;
    logic             wrap;

    // Out-of-range channel indices never match, so such writes are dropped.
    assign wr_hit = cfg_wr && (cfg_ch == CH_W'(i));
    assign wrap   = (cnt == div_act - CNT_W'(1));

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt      <= '0;
        tick     <= 1'b1;
        div_act  <= CNT_W'(DEFAULT_DIV);
        div_pend <= '0;
        pend     <= 1'b0;
      end else if (sync) begin
        cnt  <= '0;
        tick <= 1'b1;
        pend <= 1'b0;
        if (wr_hit) begin
          div_act  <= clamp_div(cfg_div);
          div_pend <= clamp_div(cfg_div);
        end else if (pend) begin
          div_act <= div_pend;
        end
      end else begin
        if (en) begin
          if (wrap) begin
            cnt  <= '0;
            tick <= 1'b1;
            if (pend) begin
              div_act <= div_pend;
              pend    <= 1'b0;
            end
          end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
          end
        end
        // A write landing on the wrap cycle stays pending for the next wrap.
        if (wr_hit) begin
          div_pend <= clamp_div(cfg_div);
          pend     <= 1'b1;
        end
      end
    end

    assign ce[i]          = en & tick;
    assign cfg_pending[i] = pend;
  end

endmodule

// File: tb/tb_multi_channel_enable_generator.sv
// Directed-vector bench for multi_channel_enable_generator (4 channels, 16-bit, default ratio 3).
module tb_multi_channel_enable_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic [3:0]  ce;
  logic [3:0]  cfg_pending;

  int vectors = 0;
  int miscompares = 0;

  multi_channel_enable_generator #(
    .NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .ce(ce), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, leave 1ns for ce to settle.
  task automatic cyc(input logic r, input logic e, input logic s, input logic w,
                     input logic [1:0] ch, input logic [15:0] dv);
    @(negedge clk);
    rst = r; en = e; sync = s; cfg_wr = w; cfg_ch = ch; cfg_div = dv;
    #1;
  endtask

  logic [3:0] rt_ce   [8] = '{4'hF, 4'h0, 4'hD, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
  logic [3:0] rt_pend [8] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] ww_ce   [8] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hB, 4'h4};
  logic [3:0] ww_pend [8] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] sy_ce   [7] = '{4'hF, 4'h0, 4'h3, 4'h4, 4'h3, 4'h8, 4'h7};
  logic       gt_en   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] gt_ce   [6] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
  logic       rs_en   [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
  logic       rs_wr   [14] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  logic [15:0] rs_dv  [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  logic [3:0] rs_ce   [14] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF,
                               4'h1, 4'h1, 4'hF, 4'h0, 4'h1, 4'h1, 4'hF};
  logic [3:0] rs_pend [14] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0,
                               4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};

  initial begin
    int gap_hits;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Free run at the default ratio of 3.
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("run_ce", ce, (k % 3 == 0) ? 4'hF : 4'h0);
      chk("run_pend", cfg_pending, 4'h0);
    end

    // Program ratio 2 everywhere with en low, then apply via sync.
    for (int c = 0; c < 4; c++) begin
      cyc(0, 0, 0, 1, 2'(c), 16'd2);
      chk("wr_pend", cfg_pending, 4'((1 << c) - 1));
    end
    cyc(0, 0, 1, 0, 0, 0);
    chk("pre_sync_pend", cfg_pending, 4'hF);

    for (int k = 0; k < 6; k++) begin
      cyc(0, gt_en[k], 0, 0, 0, 0);
      chk("gated_ce", ce, gt_ce[k]);
      chk("gated_pend", cfg_pending, 4'h0);
    end

    // ch1 -> ratio 4 by sync write-through, then reprogram to 2 mid-period.
    cyc(0, 1, 1, 1, 2'd1, 16'd4);
    for (int h = 0; h < 8; h++) begin
      cyc(0, 1, 0, (h == 1), 2'd1, 16'd2);
      chk("rt_ce", ce, rt_ce[h]);
      chk("rt_pend", cfg_pending, rt_pend[h]);
    end

    // Write ch2 on its wrap cycle: applied one wrap later.
    for (int h = 0; h < 8; h++) begin
      cyc(0, 1, 0, (h == 1), 2'd2, 16'd3);
      chk("wrapwr_ce", ce, ww_ce[h]);
      chk("wrapwr_pend", cfg_pending, ww_pend[h]);
    end

    // sync together with a write to ch3.
    cyc(0, 1, 1, 1, 2'd3, 16'd5);
    chk("sync_cyc_ce", ce, 4'hB);
    for (int h = 0; h < 7; h++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("sync_ce", ce, sy_ce[h]);
      chk("sync_pend", cfg_pending, 4'h0);
    end

    // ch0 -> ratio 5, pending write at cnt=1, reset at cnt=2 with a write to ch1.
    cyc(0, 1, 1, 1, 2'd0, 16'd5);
    chk("r_sync_ce", ce, 4'h0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("r0_ce", ce, 4'hF);
    cyc(0, 1, 0, 1, 2'd0, 16'd7);
    chk("r1_ce", ce, 4'h0);
    cyc(1, 1, 0, 1, 2'd1, 16'd9);
    chk("r2_ce", ce, 4'h2);
    chk("r2_pend", cfg_pending, 4'h1);

    // After reset: default ratio 3, then ratio 0 and 1 on ch0.
    for (int k = 0; k < 14; k++) begin
      cyc(0, rs_en[k], 0, rs_wr[k], 2'd0, rs_dv[k]);
      chk("post_rst_ce", ce, rs_ce[k]);
      chk("post_rst_pend", cfg_pending, rs_pend[k]);
    end

    // Maximum ratio on ch3.
    cyc(0, 1, 1, 1, 2'd3, 16'hFFFF);
    chk("max_sync_ce", ce, 4'h1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("max_s0_ce", ce, 4'hF);
    gap_hits = 0;
    for (int s = 1; s < 65535; s++) begin
      cyc(0, 1, 0, 0, 0, 0);
      if (ce[3]) gap_hits++;
    end
    chk("max_gap_hits", gap_hits, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("max_pulse", ce[3], 1'b1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("max_after", ce[3], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
